banked_register_file: RTL and testbench

- Responder side of the CPU register-file interface: serves register reads, register writes, CPSR read/write, mode read and SPSR restore requests issued by the fetch, ALU, branch and SDT units.
- Implements ARM7 mode banking: 31 general registers and 5 SPSRs, plus an exception-entry port.
- Sits beside the cpu core and is instantiated at top level, wired onto the shared reg_* / cpsr_* / mode_* nets.

---
 rtl/arm_regfile_pkg.sv | 40 ++++
 rtl/banked_register_file_bank_map.sv | 55 +++++
 rtl/banked_register_file.sv | 120 ++++++++++++
 tb/tb_banked_register_file.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_regfile_pkg.sv
// Shared definitions for the ARM7 banked register file: mode encodings,
// physical register layout, SPSR indices and CPSR bit positions.
package arm_regfile_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  // Physical layout: 0-15 user bank, then the banked copies packed behind it.
  localparam int         NUM_PHYS_REGS = 31;
  localparam int         NUM_SPSRS     = 5;
  localparam logic [4:0] PHYS_R15      = 5'd15;
  localparam logic [4:0] PHYS_FIQ_R8   = 5'd16;
  localparam logic [4:0] PHYS_IRQ_R13  = 5'd23;
  localparam logic [4:0] PHYS_SVC_R13  = 5'd25;
  localparam logic [4:0] PHYS_ABT_R13  = 5'd27;
  localparam logic [4:0] PHYS_UND_R13  = 5'd29;

  typedef enum logic [2:0] {
    SPSR_FIQ = 3'd0,
    SPSR_IRQ = 3'd1,
    SPSR_SVC = 3'd2,
    SPSR_ABT = 3'd3,
    SPSR_UND = 3'd4
  } spsr_idx_t;

  localparam int CPSR_I    = 7;
  localparam int CPSR_F    = 6;
  localparam int CPSR_M_HI = 4;
  localparam int CPSR_M_LO = 0;

  function automatic logic [31:0] align_pc(input logic [31:0] value);
    return {value[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/banked_register_file_bank_map.sv
// Combinational translation of (mode, logical register) into a physical
// register index, plus whether the mode owns an SPSR and which one.
module bank_map
  import arm_regfile_pkg::*;
(
  input  logic [4:0] mode,
  input  logic [3:0] reg_idx,
  output logic [4:0] phys_idx,
  output logic       spsr_valid,
  output spsr_idx_t  spsr_idx
);

  logic       is_hi_banked;
  logic [4:0] hi_offset;

  assign is_hi_banked = (reg_idx == 4'd13) || (reg_idx == 4'd14);
  assign hi_offset    = {4'b0000, ~reg_idx[0]};

  // Unlisted modes fall through to the user bank with no SPSR.
  always_comb begin
    phys_idx   = {1'b0, reg_idx};
    spsr_valid = 1'b0;
    spsr_idx   = SPSR_FIQ;
    case (mode)
      MODE_FIQ: begin
        spsr_valid = 1'b1;
        spsr_idx   = SPSR_FIQ;
        if (reg_idx >= 4'd8 && reg_idx <= 4'd14)
          phys_idx = PHYS_FIQ_R8 + {2'b00, reg_idx[2:0]};
      end
      MODE_IRQ: begin
        spsr_valid = 1'b1;
        spsr_idx   = SPSR_IRQ;
        if (is_hi_banked) phys_idx = PHYS_IRQ_R13 + hi_offset;
      end
      MODE_SVC: begin
        spsr_valid = 1'b1;
        spsr_idx   = SPSR_SVC;
        if (is_hi_banked) phys_idx = PHYS_SVC_R13 + hi_offset;
      end
      MODE_ABT: begin
        spsr_valid = 1'b1;
        spsr_idx   = SPSR_ABT;
        if (is_hi_banked) phys_idx = PHYS_ABT_R13 + hi_offset;
      end
      MODE_UND: begin
        spsr_valid = 1'b1;
        spsr_idx   = SPSR_UND;
        if (is_hi_banked) phys_idx = PHYS_UND_R13 + hi_offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/banked_register_file.sv
// ARM7 register file responder: banked GPRs, CPSR/SPSRs, registered read
// ports and a single-edge exception-entry port.
module banked_register_file
  import arm_regfile_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_read_en,
  input  logic [3:0]  reg_read_reg,
  output logic [31:0] reg_read_value,
  input  logic        reg_write_en,
  input  logic [3:0]  reg_write_reg,
  input  logic [31:0] reg_write_value,
  input  logic        reg_write_restore_from_SPSR,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value,
  input  logic        exc_en,
  input  logic [4:0]  exc_mode,
  input  logic [31:0] exc_vector,
  input  logic [31:0] exc_return_addr
);

  logic [31:0] regs [0:NUM_PHYS_REGS-1];
  logic [31:0] spsr [0:NUM_SPSRS-1];
  logic [31:0] cpsr;

  logic [4:0]  rd_phys;
  logic        rd_spsr_valid_unused;
  spsr_idx_t   rd_spsr_idx_unused;
  logic [4:0]  wr_phys;
  logic        wr_spsr_valid;
  spsr_idx_t   wr_spsr_idx;
  logic [4:0]  exc_r14_phys;
  logic        exc_mode_valid;
  spsr_idx_t   exc_spsr_idx;

  logic        exc_active;
  logic        wr_is_pc;
  logic        restore_active;
  logic [31:0] exc_cpsr;

  bank_map u_read_map (
    .mode       (cpsr[CPSR_M_HI:CPSR_M_LO]),
    .reg_idx    (reg_read_reg),
    .phys_idx   (rd_phys),
    .spsr_valid (rd_spsr_valid_unused),
    .spsr_idx   (rd_spsr_idx_unused)
  );

  bank_map u_write_map (
    .mode       (cpsr[CPSR_M_HI:CPSR_M_LO]),
    .reg_idx    (reg_write_reg),
    .phys_idx   (wr_phys),
    .spsr_valid (wr_spsr_valid),
    .spsr_idx   (wr_spsr_idx)
  );

  // Target mode's R14 slot; only exception modes report an SPSR.
  bank_map u_exc_map (
    .mode       (exc_mode),
    .reg_idx    (4'd14),
    .phys_idx   (exc_r14_phys),
    .spsr_valid (exc_mode_valid),
    .spsr_idx   (exc_spsr_idx)
  );

  assign exc_active     = exc_en && exc_mode_valid;
  assign wr_is_pc       = reg_write_en && (reg_write_reg == 4'd15);
  assign restore_active = wr_is_pc && reg_write_restore_from_SPSR && wr_spsr_valid;

  always_comb begin
    exc_cpsr                      = cpsr;
    exc_cpsr[CPSR_M_HI:CPSR_M_LO] = exc_mode;
    exc_cpsr[CPSR_I]              = 1'b1;
    if (exc_mode == MODE_FIQ) exc_cpsr[CPSR_F] = 1'b1;
  end

  // Exception updates are placed last so they win any same-edge conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < NUM_SPSRS; i++) spsr[i] <= '0;
      regs[PHYS_R15]  <= align_pc(RESET_PC);
      cpsr            <= RESET_CPSR;
      reg_read_value  <= '0;
      cpsr_read_value <= '0;
      mode_read_value <= '0;
    end else begin
      if (reg_read_en)  reg_read_value  <= regs[rd_phys];
      if (cpsr_read_en) cpsr_read_value <= cpsr;
      if (mode_read_en) mode_read_value <= {27'b0, cpsr[CPSR_M_HI:CPSR_M_LO]};

      if (reg_write_en) begin
        if (!wr_is_pc)
          regs[wr_phys] <= reg_write_value;
        else if (!exc_active)
          regs[PHYS_R15] <= align_pc(reg_write_value);
      end

      if (exc_active) begin
        spsr[exc_spsr_idx]  <= cpsr;
        regs[exc_r14_phys]  <= exc_return_addr;
        regs[PHYS_R15]      <= align_pc(exc_vector);
        cpsr                <= exc_cpsr;
      end else if (restore_active) begin
        cpsr <= spsr[wr_spsr_idx];
      end else if (cpsr_write_en) begin
        cpsr <= cpsr_write_value;
      end
    end
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a bank-level model.
module tb_banked_register_file;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;

  logic        clk;
  logic        rst;
  logic        reg_read_en;
  logic [3:0]  reg_read_reg;
  logic [31:0] reg_read_value;
  logic        reg_write_en;
  logic [3:0]  reg_write_reg;
  logic [31:0] reg_write_value;
  logic        reg_write_restore_from_SPSR;
  logic        cpsr_read_en;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en;
  logic [31:0] cpsr_write_value;
  logic        mode_read_en;
  logic [31:0] mode_read_value;
  logic        exc_en;
  logic [4:0]  exc_mode;
  logic [31:0] exc_vector;
  logic [31:0] exc_return_addr;

  int checks   = 0;
  int failures = 0;
  logic check_en = 1'b0;

  banked_register_file dut (
    .clk                         (clk),
    .rst                         (rst),
    .reg_read_en                 (reg_read_en),
    .reg_read_reg                (reg_read_reg),
    .reg_read_value              (reg_read_value),
    .reg_write_en                (reg_write_en),
    .reg_write_reg               (reg_write_reg),
    .reg_write_value             (reg_write_value),
    .reg_write_restore_from_SPSR (reg_write_restore_from_SPSR),
    .cpsr_read_en                (cpsr_read_en),
    .cpsr_read_value             (cpsr_read_value),
    .cpsr_write_en               (cpsr_write_en),
    .cpsr_write_value            (cpsr_write_value),
    .mode_read_en                (mode_read_en),
    .mode_read_value             (mode_read_value),
    .exc_en                      (exc_en),
    .exc_mode                    (exc_mode),
    .exc_vector                  (exc_vector),
    .exc_return_addr             (exc_return_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 6 banks (0 user, 1 FIQ, 2 IRQ, 3 SVC, 4 ABT, 5 UND) of 16 logical regs.
  logic [31:0] m_regs [0:5][0:15];
  logic [31:0] m_spsr [0:5];
  logic [31:0] m_cpsr;
  logic [31:0] exp_reg, exp_cpsr, exp_mode;

  function automatic int bank_of(input logic [4:0] m);
    case (m)
      M_FIQ:   return 1;
      M_IRQ:   return 2;
      M_SVC:   return 3;
      M_ABT:   return 4;
      M_UND:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int owner(input int b, input int r);
    if (r < 8 || r == 15) return 0;
    if (b == 1) return 1;
    if (r >= 13 && b >= 2) return b;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int          b, eb;
    logic [31:0] old_cpsr;
    logic        exc_ok, restore_ok;
    if (rst) begin
      for (int k = 0; k < 6; k++) begin
        m_spsr[k] = '0;
        for (int r = 0; r < 16; r++) m_regs[k][r] = '0;
      end
      m_cpsr   = 32'h0000_00D3;
      exp_reg  = '0;
      exp_cpsr = '0;
      exp_mode = '0;
    end else begin
      old_cpsr = m_cpsr;
      b        = bank_of(old_cpsr[4:0]);
      if (reg_read_en)  exp_reg  = m_regs[owner(b, int'(reg_read_reg))][reg_read_reg];
      if (cpsr_read_en) exp_cpsr = old_cpsr;
      if (mode_read_en) exp_mode = {27'b0, old_cpsr[4:0]};
      eb         = bank_of(exc_mode);
      exc_ok     = exc_en && (eb != 0);
      restore_ok = reg_write_en && reg_write_reg == 4'd15 && reg_write_restore_from_SPSR && b != 0;
      if (reg_write_en) begin
        if (reg_write_reg != 4'd15)
          m_regs[owner(b, int'(reg_write_reg))][reg_write_reg] = reg_write_value;
        else if (!exc_ok)
          m_regs[0][15] = reg_write_value & 32'hFFFF_FFFC;
      end
      if (exc_ok) begin
        m_spsr[eb]     = old_cpsr;
        m_regs[eb][14] = exc_return_addr;
        m_regs[0][15]  = exc_vector & 32'hFFFF_FFFC;
        m_cpsr         = {old_cpsr[31:8], 1'b1, (eb == 1) ? 1'b1 : old_cpsr[6], old_cpsr[5], exc_mode};
      end else if (restore_ok) begin
        m_cpsr = m_spsr[b];
      end else if (cpsr_write_en) begin
        m_cpsr = cpsr_write_value;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model reg_read_value", reg_read_value, exp_reg);
      checkOutput("model cpsr_read_value", cpsr_read_value, exp_cpsr);
      checkOutput("model mode_read_value", mode_read_value, exp_mode);
    end
  end

  task automatic clearInputs();
    rst                         = 1'b0;
    reg_read_en                 = 1'b0;
    reg_read_reg                = '0;
    reg_write_en                = 1'b0;
    reg_write_reg               = '0;
    reg_write_value             = '0;
    reg_write_restore_from_SPSR = 1'b0;
    cpsr_read_en                = 1'b0;
    cpsr_write_en               = 1'b0;
    cpsr_write_value            = '0;
    mode_read_en                = 1'b0;
    exc_en                      = 1'b0;
    exc_mode                    = '0;
    exc_vector                  = '0;
    exc_return_addr             = '0;
  endtask

  // Clocks the currently driven inputs into the DUT, then idles them.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic doWrite(input logic [3:0] r, input logic [31:0] v);
    reg_write_en = 1'b1; reg_write_reg = r; reg_write_value = v;
    applyStimulus();
  endtask

  task automatic doRead(input logic [3:0] r);
    reg_read_en = 1'b1; reg_read_reg = r;
    applyStimulus();
  endtask

  task automatic doCpsrWrite(input logic [31:0] v);
    cpsr_write_en = 1'b1; cpsr_write_value = v;
    applyStimulus();
  endtask

  task automatic doCpsrRead();
    cpsr_read_en = 1'b1; mode_read_en = 1'b1;
    applyStimulus();
  endtask

  function automatic logic [4:0] pickMode();
    logic [4:0] modes [0:7];
    modes = '{M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS, 5'b00101};
    return modes[$urandom_range(0, 7)];
  endfunction

  initial begin
    logic [31:0] rnd;
    clearInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    rst = 1'b1;
    applyStimulus();

    doCpsrRead();
    checkOutput("reset cpsr", cpsr_read_value, 32'h0000_00D3);
    checkOutput("reset mode", mode_read_value, 32'h0000_0013);

    doWrite(4'd13, 32'h1000);
    doCpsrWrite(32'h10);
    doWrite(4'd13, 32'h2000);
    doRead(4'd13);
    checkOutput("usr r13", reg_read_value, 32'h2000);
    doCpsrWrite(32'h13);
    doRead(4'd13);
    checkOutput("svc r13", reg_read_value, 32'h1000);

    doCpsrWrite(32'h10);
    doWrite(4'd8, 32'hAA);
    exc_en = 1'b1; exc_mode = M_FIQ; exc_vector = 32'h1C; exc_return_addr = 32'h40;
    applyStimulus();
    doCpsrRead();
    checkOutput("fiq entry cpsr", cpsr_read_value, 32'hD1);
    doRead(4'd14);
    checkOutput("fiq r14", reg_read_value, 32'h40);
    doRead(4'd15);
    checkOutput("fiq pc", reg_read_value, 32'h1C);
    doRead(4'd8);
    checkOutput("fiq r8", reg_read_value, 32'h0);

    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h41;
    reg_write_restore_from_SPSR = 1'b1;
    applyStimulus();
    doRead(4'd15);
    checkOutput("restore pc", reg_read_value, 32'h40);
    doCpsrRead();
    checkOutput("restore cpsr", cpsr_read_value, 32'h10);
    doRead(4'd8);
    checkOutput("usr r8", reg_read_value, 32'hAA);

    exc_en = 1'b1; exc_mode = M_IRQ; exc_vector = 32'h18; exc_return_addr = 32'h1234;
    cpsr_write_en = 1'b1; cpsr_write_value = 32'h1F;
    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h80;
    applyStimulus();
    doCpsrRead();
    checkOutput("priority cpsr", cpsr_read_value, 32'h92);
    checkOutput("priority mode", mode_read_value, 32'h12);
    doRead(4'd15);
    checkOutput("priority pc", reg_read_value, 32'h18);
    doRead(4'd14);
    checkOutput("irq r14", reg_read_value, 32'h1234);

    doWrite(4'd3, 32'h11);
    reg_read_en = 1'b1; reg_read_reg = 4'd3;
    reg_write_en = 1'b1; reg_write_reg = 4'd3; reg_write_value = 32'h55;
    applyStimulus();
    checkOutput("read before write", reg_read_value, 32'h11);
    doRead(4'd3);
    checkOutput("read after write", reg_read_value, 32'h55);

    rst = 1'b1;
    reg_write_en = 1'b1; reg_write_reg = 4'd3; reg_write_value = 32'h99;
    cpsr_write_en = 1'b1; cpsr_write_value = 32'h1F;
    applyStimulus();
    checkOutput("reset read out", reg_read_value, 32'h0);
    doRead(4'd3);
    checkOutput("reset r3", reg_read_value, 32'h0);
    doRead(4'd13);
    checkOutput("reset svc r13", reg_read_value, 32'h0);
    doRead(4'd15);
    checkOutput("reset pc", reg_read_value, 32'h0);
    doCpsrRead();
    checkOutput("reset cpsr again", cpsr_read_value, 32'hD3);

    for (int i = 0; i < 800; i++) begin
      rst                         = ($urandom_range(0, 99) == 0);
      reg_read_en                 = 1'($urandom_range(0, 1));
      reg_read_reg                = 4'($urandom_range(0, 15));
      reg_write_en                = 1'($urandom_range(0, 1));
      reg_write_reg               = 4'($urandom_range(0, 15));
      reg_write_value             = $urandom;
      reg_write_restore_from_SPSR = ($urandom_range(0, 2) == 0);
      cpsr_read_en                = 1'($urandom_range(0, 1));
      mode_read_en                = 1'($urandom_range(0, 1));
      cpsr_write_en               = ($urandom_range(0, 5) == 0);
      rnd                         = $urandom;
      cpsr_write_value            = {rnd[31:5], pickMode()};
      exc_en                      = ($urandom_range(0, 7) == 0);
      exc_mode                    = pickMode();
      exc_vector                  = $urandom;
      exc_return_addr             = $urandom;
      applyStimulus();
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
